// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with per-entry saturating counters and round-robin victims.
// Optional build macro BTB_ASSOC_BYPASS_EN forwards a same-cycle update to a matching lookup.
module btb_assoc #(
   parameter int SETS     = 16,
   parameter int WAYS     = 2,
   parameter int CTR_BITS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [31:0] fetch_pc,
   output logic [31:0] fetch_target,
   output logic        fetch_taken,
   output logic        fetch_hit,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic [31:0] upd_target,
   input  logic        upd_taken,
   input  logic        upd_is_jump
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 30 - IDX_W;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
   localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));

   logic                valid_q  [SETS][WAYS];
   logic                valid_d  [SETS][WAYS];
   logic [TAG_W-1:0]    tag_q    [SETS][WAYS];
   logic [TAG_W-1:0]    tag_d    [SETS][WAYS];
   logic [31:0]         target_q [SETS][WAYS];
   logic [31:0]         target_d [SETS][WAYS];
   logic [CTR_BITS-1:0] ctr_q    [SETS][WAYS];
   logic [CTR_BITS-1:0] ctr_d    [SETS][WAYS];
   logic [WAY_W-1:0]    rr_q     [SETS];
   logic [WAY_W-1:0]    rr_d     [SETS];

   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] u_tag;
   logic             u_hit;
   logic [WAY_W-1:0] u_way;
   logic             inv_found;
   logic [WAY_W-1:0] inv_way;
   logic [WAY_W-1:0] victim;
   logic             u_taken;

   assign u_idx   = upd_pc[IDX_W+1:2];
   assign u_tag   = upd_pc[31:IDX_W+2];
   assign u_taken = upd_is_jump | upd_taken;

   always_comb begin
      u_hit     = 1'b0;
      u_way     = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) begin
            u_hit = 1'b1;
            u_way = WAY_W'(w);
         end
      end
      // Scan downwards so the lowest-index invalid way wins.
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_q[u_idx][w]) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
      victim = inv_found ? inv_way : rr_q[u_idx];
   end

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      rr_d     = rr_q;
      if (flush) begin
         for (int s = 0; s < SETS; s++) begin
            rr_d[s] = '0;
            for (int w = 0; w < WAYS; w++) begin
               valid_d[s][w] = 1'b0;
            end
         end
      end else if (upd_valid) begin
         if (u_hit) begin
            if (upd_is_jump) begin
               ctr_d[u_idx][u_way] = CTR_MAX;
            end else if (upd_taken) begin
               if (ctr_q[u_idx][u_way] != CTR_MAX) begin
                  ctr_d[u_idx][u_way] = ctr_q[u_idx][u_way] + 1'b1;
               end
            end else if (ctr_q[u_idx][u_way] != '0) begin
               ctr_d[u_idx][u_way] = ctr_q[u_idx][u_way] - 1'b1;
            end
            if (u_taken) begin
               target_d[u_idx][u_way] = upd_target;
            end
         end else if (u_taken) begin
            valid_d[u_idx][victim]  = 1'b1;
            tag_d[u_idx][victim]    = u_tag;
            target_d[u_idx][victim] = upd_target;
            ctr_d[u_idx][victim]    = upd_is_jump ? CTR_MAX : CTR_WEAK;
            if (!inv_found && (WAYS > 1)) begin
               rr_d[u_idx] = rr_q[u_idx] + 1'b1;
            end
         end
      end
   end

   // Tags and targets carry no reset; an entry is only meaningful while valid.
   always_ff @(posedge clk) begin
      tag_q    <= tag_d;
      target_q <= target_d;
      if (rst) begin
         for (int s = 0; s < SETS; s++) begin
            rr_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               valid_q[s][w] <= 1'b0;
               ctr_q[s][w]   <= '0;
            end
         end
      end else begin
         valid_q <= valid_d;
         ctr_q   <= ctr_d;
         rr_q    <= rr_d;
      end
   end

   logic [IDX_W-1:0]    f_idx;
   logic [TAG_W-1:0]    f_tag;
   logic                v_valid [WAYS];
   logic [TAG_W-1:0]    v_tag   [WAYS];
   logic [CTR_BITS-1:0] v_ctr   [WAYS];
   logic [31:0]         v_tgt   [WAYS];
   logic                f_hit;
   logic [CTR_BITS-1:0] f_ctr;
   logic [31:0]         f_tgt;

   assign f_idx = fetch_pc[IDX_W+1:2];
   assign f_tag = fetch_pc[31:IDX_W+2];

`ifdef BTB_ASSOC_BYPASS_EN
   logic fwd;
   assign fwd = upd_valid && !rst && !flush && (u_idx == f_idx) && (u_tag == f_tag);
`endif

   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         v_valid[w] = valid_q[f_idx][w];
         v_tag[w]   = tag_q[f_idx][w];
         v_ctr[w]   = ctr_q[f_idx][w];
         v_tgt[w]   = target_q[f_idx][w];
`ifdef BTB_ASSOC_BYPASS_EN
         // Matching update: present the set as it will look after this edge.
         if (fwd) begin
            v_valid[w] = valid_d[f_idx][w];
            v_tag[w]   = tag_d[f_idx][w];
            v_ctr[w]   = ctr_d[f_idx][w];
            v_tgt[w]   = target_d[f_idx][w];
         end
`endif
      end
   end

   always_comb begin
      f_hit = 1'b0;
      f_ctr = '0;
      f_tgt = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (v_valid[w] && (v_tag[w] == f_tag)) begin
            f_hit = 1'b1;
            f_ctr = v_ctr[w];
            f_tgt = v_tgt[w];
         end
      end
   end

   assign fetch_hit    = f_hit;
   assign fetch_taken  = f_hit && f_ctr[CTR_BITS-1];
   assign fetch_target = fetch_taken ? f_tgt : fetch_pc + 32'd4;

endmodule
